paging_unit: RTL and testbench
==============================

# paging_unit

Translates the 32-bit linear address produced by the segmentation unit into a 32-bit physical address using 80386 two-level paging (4 KiB pages). It sits between the segmentation unit and the bus interface unit. It holds a small fully-associative TLB and a page-walk state machine that fetches the PDE and PTE over a dedicated memory read port. Permission violations and non-present entries raise a page fault with the faulting linear address, which is the CR2 value.

## Interface
- TLB_ENTRIES, 4: number of TLB entries; a power of two, 2..16.
- clock  input  1  sole clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- i_paging_enable  input  1  CR0.PG
- i_page_directory_base  input  20  CR3[31:12]
- i_tlb_flush  input  1  single-cycle pulse; invalidates all TLB entries (CR3 write)
- i_request_valid  input  1  translation request
- o_request_ready  output  1  request can be accepted this cycle
- i_linear_address  input  32  from segmentation_unit o_linear_address
- i_write_enable  input  1  access is a write
- i_user_mode  input  1  CPL == 3
- o_response_valid  output  1  single-cycle result pulse
- o_physical_address  output  32  valid with o_response_valid and !o_page_fault
- o_page_fault  output  1  valid with o_response_valid
- o_fault_linear_address  output  32  latched linear address of the last fault
- o_memory_request  output  1  page-walk read request; held until data returns
- o_memory_address  output  32  dword-aligned PDE/PTE address
- i_memory_data_valid  input  1  read data return
- i_memory_data  input  32  PDE/PTE contents

## Operation
- FSM states: IDLE, RESPOND, WALK_PDE, WALK_PTE, FILL.
- o_request_ready is 1 only in IDLE. A request is accepted when i_request_valid & o_request_ready. On acceptance, latch the linear address, write and user flags.
- Paging disabled: physical = linear; go to RESPOND with no fault.
- TLB hit (valid entry with tag == linear[31:12]): run the permission check; go to RESPOND.
- TLB miss: enter WALK_PDE and drive o_memory_address = {CR3 base, linear[31:22], 2'b00}.
  - PDE with P=0: fault.
  - Otherwise enter WALK_PTE and drive address = {PDE[31:12], linear[21:12], 2'b00}.
  - PTE with P=0: fault.
  - Otherwise enter FILL.
- FILL writes the TLB entry {tag, PTE[31:12], U = PDE.U & PTE.U, W = PDE.W & PTE.W}, runs the permission check, then goes to RESPOND.
- Permission check:
  - Fault if i_user_mode & !U.
  - Fault if i_user_mode & write & !W.
  - Supervisor accesses are never protection-faulted.
- Physical address = {frame, linear[11:0]}.
- On a fault, o_fault_linear_address takes the latched linear address. The TLB is not filled for a fault.
- Replacement: a round-robin pointer that advances on each fill.
- Accessed and dirty bits are not written back.

## Timing
- Reset values:
  - State IDLE.
  - All TLB valid bits 0; replacement pointer 0.
  - o_request_ready 1.
  - o_response_valid, o_page_fault and o_memory_request 0.
  - o_physical_address and o_fault_linear_address 0.
- Hit or paging disabled: request accepted in cycle N; o_response_valid in cycle N+1 for exactly one cycle; o_request_ready is 0 in N+1.
- Miss, PDE read:
  - o_memory_request rises in cycle N+1.
  - Address stays stable until the cycle in which i_memory_data_valid is 1.
  - Request and data in the same cycle is legal.
- Miss, PTE read: o_memory_request stays asserted into the next cycle with the PTE address.
- Miss, end of walk: PTE data in cycle M, FILL in M+1, response in M+2.
- PDE fault: the response comes in the cycle after the PDE data.
- The consumer always accepts o_response_valid; there is no backpressure.
- i_tlb_flush takes effect in the next cycle in any state.
  - If a flush and a FILL write coincide, the flush wins and the entry stays invalid.
  - A walk in progress completes and responds normally.
- Reset asserted mid-walk aborts immediately. i_memory_data_valid that arrives after reset is released is ignored in IDLE.
- i_memory_data_valid outside WALK_PDE and WALK_PTE is ignored.

## Configuration
- PAGING_UNIT_TLB_EN defined: TLB present as described.
- PAGING_UNIT_TLB_EN undefined:
  - No TLB storage.
  - Every paged request performs the full walk; hits never occur.
  - i_tlb_flush is ignored.
  - TLB_ENTRIES is unused.

## Structure
- Shared package paging_pkg contains:
  - The state enum.
  - The tlb_entry_t struct (valid, tag[19:0], frame[19:0], user, writable).
  - Bit-position constants for the PDE/PTE P, W and U fields.
- One sub-module, paging_tlb, covers lookup, fill, flush and the round-robin pointer. It is instantiated only under PAGING_UNIT_TLB_EN.

## Test plan
- Paging disabled, linear 0x1234_5678 → response in cycle N+1; physical 0x1234_5678; no fault; no memory request.
- Paging enabled, CR3 base 0x00010, linear 0x0040_3ABC:
  - PDE read at 0x0001_0004, returning 0x0002_0007.
  - PTE read at 0x0002_000C, returning 0x0ABC_D007.
  - Expect physical 0x0ABC_DABC at M+2.
  - Repeating the request hits at N+1 with no memory request.
- User-mode write to a page whose PTE has W=0 (e.g. 0x0ABC_D005) → o_page_fault=1; o_fault_linear_address = request address; no TLB fill, so a repeat walks again.
- PDE returns 0x0000_0000 → fault one cycle after the PDE data; no PTE read issued.
- i_tlb_flush pulsed on the FILL cycle → the response is still correct; the next request to the same page walks.
- Reset asserted during WALK_PTE → o_memory_request drops immediately; all outputs at reset values; a stale i_memory_data_valid after release is ignored.

Source files
------------

// File: rtl/paging_pkg.sv
// paging_pkg: types and constants shared by the paging unit and its TLB.
//   state_t      - page-walk FSM states
//   tlb_entry_t  - one TLB entry {valid, tag, frame, user, writable}
//   ENTRY_*_BIT  - bit positions of P, W and U in a PDE/PTE
//   perm_fault() - 80386 user/supervisor and read/write protection check
package paging_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESPOND,
        WALK_PDE,
        WALK_PTE,
        FILL
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [19:0] tag;
        logic [19:0] frame;
        logic        user;
        logic        writable;
    } tlb_entry_t;

    localparam int unsigned ENTRY_P_BIT = 0;
    localparam int unsigned ENTRY_W_BIT = 1;
    localparam int unsigned ENTRY_U_BIT = 2;

    // Supervisor accesses are never protection-faulted.
    function automatic logic perm_fault(input logic user_mode, input logic write,
                                        input logic user_ok, input logic writable);
        return user_mode & (!user_ok | (write & !writable));
    endfunction

endpackage

// File: rtl/paging_tlb.sv
// paging_tlb: fully-associative translation lookaside buffer.
//   clock, reset    - clock, asynchronous active-low reset
//   flush           - invalidate all entries at the next edge (wins over fill)
//   lookup_tag      - linear[31:12] to look up (combinational result)
//   hit, hit_*      - lookup result: frame, user and writable flags
//   fill            - write fill_entry at the round-robin pointer
//   fill_entry      - entry to write
module paging_tlb
    import paging_pkg::*;
#(
    parameter int unsigned TLB_ENTRIES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [19:0] lookup_tag,
    output logic        hit,
    output logic [19:0] hit_frame,
    output logic        hit_user,
    output logic        hit_writable,
    input  logic        fill,
    input  tlb_entry_t  fill_entry
);

    localparam int unsigned PTR_W = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;

    tlb_entry_t       entries [TLB_ENTRIES];
    logic [PTR_W-1:0] ptr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
                entries[i] <= '0;
            end
            ptr <= '0;
        end else begin
            if (fill) begin
                ptr <= ptr + 1'b1;
            end
            if (flush) begin
                for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
                    entries[i].valid <= 1'b0;
                end
            end else if (fill) begin
                entries[ptr] <= fill_entry;
            end
        end
    end

    always_comb begin
        hit          = 1'b0;
        hit_frame    = '0;
        hit_user     = 1'b0;
        hit_writable = 1'b0;
        for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
            if (entries[i].valid && entries[i].tag == lookup_tag) begin
                hit          = 1'b1;
                hit_frame    = entries[i].frame;
                hit_user     = entries[i].user;
                hit_writable = entries[i].writable;
            end
        end
    end

endmodule

// File: rtl/paging_unit.sv
// paging_unit: 80386 two-level paging (4 KiB pages), linear -> physical.
// Optional TLB enabled by defining PAGING_UNIT_TLB_EN; without it every
// paged request walks the tables and i_tlb_flush is ignored.
//   clock, reset               - clock, asynchronous active-low reset
//   i_paging_enable            - CR0.PG
//   i_page_directory_base      - CR3[31:12]
//   i_tlb_flush                - invalidate all TLB entries
//   i_request_valid/o_request_ready, i_linear_address, i_write_enable,
//   i_user_mode                - translation request
//   o_response_valid, o_physical_address, o_page_fault - result pulse
//   o_fault_linear_address     - linear address of the last fault (CR2)
//   o_memory_request/o_memory_address, i_memory_data_valid/i_memory_data
//                              - PDE/PTE read port
module paging_unit
    import paging_pkg::*;
#(
    parameter int unsigned TLB_ENTRIES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_paging_enable,
    input  logic [19:0] i_page_directory_base,
    input  logic        i_tlb_flush,
    input  logic        i_request_valid,
    output logic        o_request_ready,
    input  logic [31:0] i_linear_address,
    input  logic        i_write_enable,
    input  logic        i_user_mode,
    output logic        o_response_valid,
    output logic [31:0] o_physical_address,
    output logic        o_page_fault,
    output logic [31:0] o_fault_linear_address,
    output logic        o_memory_request,
    output logic [31:0] o_memory_address,
    input  logic        i_memory_data_valid,
    input  logic [31:0] i_memory_data
);

    state_t      state, next_state;
    logic        accept;
    logic [31:0] lin_q;
    logic        write_q, user_q;
    logic [19:0] pde_frame_q, pte_frame_q;
    logic        pde_user_q, pde_w_q, walk_user_q, walk_w_q;

    logic        load_pde, load_pte, load_result, fill_en;
    logic        result_fault;
    logic [31:0] result_phys, result_linear;

    logic        tlb_hit, tlb_user, tlb_writable;
    logic [19:0] tlb_frame;

    logic        unused_pte_bits;
    assign unused_pte_bits = ^i_memory_data[11:3];

`ifdef PAGING_UNIT_TLB_EN
    tlb_entry_t fill_entry;
    assign fill_entry = '{valid: 1'b1, tag: lin_q[31:12], frame: pte_frame_q,
                          user: walk_user_q, writable: walk_w_q};

    paging_tlb #(.TLB_ENTRIES(TLB_ENTRIES)) u_tlb (
        .clock        (clock),
        .reset        (reset),
        .flush        (i_tlb_flush),
        .lookup_tag   (i_linear_address[31:12]),
        .hit          (tlb_hit),
        .hit_frame    (tlb_frame),
        .hit_user     (tlb_user),
        .hit_writable (tlb_writable),
        .fill         (fill_en),
        .fill_entry   (fill_entry)
    );
`else
    logic unused_tlb;
    assign unused_tlb   = ^{i_tlb_flush, fill_en, (TLB_ENTRIES > 0)};
    assign tlb_hit      = 1'b0;
    assign tlb_frame    = '0;
    assign tlb_user     = 1'b0;
    assign tlb_writable = 1'b0;
`endif

    assign o_request_ready  = (state == IDLE);
    assign o_response_valid = (state == RESPOND);
    assign accept           = i_request_valid & o_request_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state       = state;
        load_pde         = 1'b0;
        load_pte         = 1'b0;
        load_result      = 1'b0;
        fill_en          = 1'b0;
        result_fault     = 1'b0;
        result_phys      = '0;
        result_linear    = lin_q;
        o_memory_request = 1'b0;
        o_memory_address = '0;
        case (state)
            IDLE: begin
                // Lookup uses the live request so a hit responds next cycle.
                result_linear = i_linear_address;
                if (accept) begin
                    if (!i_paging_enable) begin
                        load_result = 1'b1;
                        result_phys = i_linear_address;
                        next_state  = RESPOND;
                    end else if (tlb_hit) begin
                        load_result  = 1'b1;
                        result_fault = perm_fault(i_user_mode, i_write_enable,
                                                  tlb_user, tlb_writable);
                        result_phys  = {tlb_frame, i_linear_address[11:0]};
                        next_state   = RESPOND;
                    end else begin
                        next_state = WALK_PDE;
                    end
                end
            end
            WALK_PDE: begin
                o_memory_request = 1'b1;
                o_memory_address = {i_page_directory_base, lin_q[31:22], 2'b00};
                if (i_memory_data_valid) begin
                    if (!i_memory_data[ENTRY_P_BIT]) begin
                        load_result  = 1'b1;
                        result_fault = 1'b1;
                        next_state   = RESPOND;
                    end else begin
                        load_pde   = 1'b1;
                        next_state = WALK_PTE;
                    end
                end
            end
            WALK_PTE: begin
                o_memory_request = 1'b1;
                o_memory_address = {pde_frame_q, lin_q[21:12], 2'b00};
                if (i_memory_data_valid) begin
                    if (!i_memory_data[ENTRY_P_BIT]) begin
                        load_result  = 1'b1;
                        result_fault = 1'b1;
                        next_state   = RESPOND;
                    end else begin
                        load_pte   = 1'b1;
                        next_state = FILL;
                    end
                end
            end
            FILL: begin
                load_result  = 1'b1;
                result_fault = perm_fault(user_q, write_q, walk_user_q, walk_w_q);
                result_phys  = {pte_frame_q, lin_q[11:0]};
                fill_en      = !result_fault;
                next_state   = RESPOND;
            end
            RESPOND: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lin_q                  <= '0;
            write_q                <= 1'b0;
            user_q                 <= 1'b0;
            pde_frame_q            <= '0;
            pde_user_q             <= 1'b0;
            pde_w_q                <= 1'b0;
            pte_frame_q            <= '0;
            walk_user_q            <= 1'b0;
            walk_w_q               <= 1'b0;
            o_physical_address     <= '0;
            o_page_fault           <= 1'b0;
            o_fault_linear_address <= '0;
        end else begin
            if (accept) begin
                lin_q   <= i_linear_address;
                write_q <= i_write_enable;
                user_q  <= i_user_mode;
            end
            if (load_pde) begin
                pde_frame_q <= i_memory_data[31:12];
                pde_user_q  <= i_memory_data[ENTRY_U_BIT];
                pde_w_q     <= i_memory_data[ENTRY_W_BIT];
            end
            if (load_pte) begin
                pte_frame_q <= i_memory_data[31:12];
                walk_user_q <= pde_user_q & i_memory_data[ENTRY_U_BIT];
                walk_w_q    <= pde_w_q & i_memory_data[ENTRY_W_BIT];
            end
            if (load_result) begin
                o_page_fault <= result_fault;
                if (result_fault) begin
                    o_fault_linear_address <= result_linear;
                end else begin
                    o_physical_address <= result_phys;
                end
            end
        end
    end

endmodule

// File: tb/tb_paging_unit.sv
// tb_paging_unit: directed checks of paging_unit timing, walks, faults,
// flush and reset. Expectations for repeated requests depend on whether
// PAGING_UNIT_TLB_EN is defined.
module tb_paging_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        i_paging_enable = 1'b0;
    logic [19:0] i_page_directory_base = '0;
    logic        i_tlb_flush = 1'b0;
    logic        i_request_valid = 1'b0;
    logic        o_request_ready;
    logic [31:0] i_linear_address = '0;
    logic        i_write_enable = 1'b0;
    logic        i_user_mode = 1'b0;
    logic        o_response_valid;
    logic [31:0] o_physical_address;
    logic        o_page_fault;
    logic [31:0] o_fault_linear_address;
    logic        o_memory_request;
    logic [31:0] o_memory_address;
    logic        i_memory_data_valid = 1'b0;
    logic [31:0] i_memory_data = '0;

    int checks = 0;
    int errors = 0;

    paging_unit #(.TLB_ENTRIES(4)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .i_paging_enable        (i_paging_enable),
        .i_page_directory_base  (i_page_directory_base),
        .i_tlb_flush            (i_tlb_flush),
        .i_request_valid        (i_request_valid),
        .o_request_ready        (o_request_ready),
        .i_linear_address       (i_linear_address),
        .i_write_enable         (i_write_enable),
        .i_user_mode            (i_user_mode),
        .o_response_valid       (o_response_valid),
        .o_physical_address     (o_physical_address),
        .o_page_fault           (o_page_fault),
        .o_fault_linear_address (o_fault_linear_address),
        .o_memory_request       (o_memory_request),
        .o_memory_address       (o_memory_address),
        .i_memory_data_valid    (i_memory_data_valid),
        .i_memory_data          (i_memory_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Each task starts and ends 1 time unit after a rising edge.
    task automatic issue(input logic [31:0] lin, input logic wr, input logic usr);
        i_request_valid  = 1'b1;
        i_linear_address = lin;
        i_write_enable   = wr;
        i_user_mode      = usr;
        @(negedge clock);
        chk("ready_at_N", o_request_ready, 1);
        @(posedge clock); #1;
        i_request_valid = 1'b0;
    endtask

    task automatic mem_phase(input string tag, input logic [31:0] addr,
                             input logic [31:0] data, input int unsigned delay);
        for (int unsigned d = 0; d <= delay; d++) begin
            @(negedge clock);
            chk({tag, "_req"}, o_memory_request, 1);
            chk({tag, "_addr"}, o_memory_address, addr);
            if (d == delay) begin
                i_memory_data_valid = 1'b1;
                i_memory_data       = data;
            end
            @(posedge clock); #1;
        end
        i_memory_data_valid = 1'b0;
    endtask

    task automatic fill_cycle(input logic flush);
        i_tlb_flush = flush;
        @(negedge clock);
        chk("fill_no_resp", o_response_valid, 0);
        chk("fill_no_memreq", o_memory_request, 0);
        @(posedge clock); #1;
        i_tlb_flush = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input logic fault, input logic [31:0] value);
        @(negedge clock);
        chk({tag, "_valid"}, o_response_valid, 1);
        chk({tag, "_fault"}, o_page_fault, fault);
        if (fault) chk({tag, "_cr2"}, o_fault_linear_address, value);
        else       chk({tag, "_phys"}, o_physical_address, value);
        chk({tag, "_ready_low"}, o_request_ready, 0);
        chk({tag, "_no_memreq"}, o_memory_request, 0);
        @(posedge clock); #1;
        @(negedge clock);
        chk({tag, "_one_cycle"}, o_response_valid, 0);
        chk({tag, "_ready_back"}, o_request_ready, 1);
        @(posedge clock); #1;
    endtask

    initial begin
        // Reset values
        @(negedge clock);
        chk("rst_ready", o_request_ready, 1);
        chk("rst_resp", o_response_valid, 0);
        chk("rst_fault", o_page_fault, 0);
        chk("rst_memreq", o_memory_request, 0);
        chk("rst_phys", o_physical_address, 0);
        chk("rst_cr2", o_fault_linear_address, 0);
        reset = 1'b1;
        @(posedge clock); #1;

        // Paging disabled: identity
        issue(32'h1234_5678, 1'b0, 1'b0);
        expect_resp("nopg", 1'b0, 32'h1234_5678);

        // Full walk
        i_paging_enable       = 1'b1;
        i_page_directory_base = 20'h00010;
        issue(32'h0040_3ABC, 1'b0, 1'b0);
        mem_phase("w1_pde", 32'h0001_0004, 32'h0002_0007, 0);
        mem_phase("w1_pte", 32'h0002_000C, 32'h0ABC_D007, 0);
        fill_cycle(1'b0);
        expect_resp("w1", 1'b0, 32'h0ABC_DABC);

        // Repeat: hit at N+1 with TLB, otherwise another walk
        issue(32'h0040_3ABC, 1'b0, 1'b0);
`ifndef PAGING_UNIT_TLB_EN
        mem_phase("w2_pde", 32'h0001_0004, 32'h0002_0007, 0);
        mem_phase("w2_pte", 32'h0002_000C, 32'h0ABC_D007, 1);
        fill_cycle(1'b0);
`endif
        expect_resp("rep", 1'b0, 32'h0ABC_DABC);

        // User write to read-only page faults, no fill
        issue(32'h0040_5123, 1'b1, 1'b1);
        mem_phase("ro_pde", 32'h0001_0004, 32'h0002_0007, 0);
        mem_phase("ro_pte", 32'h0002_0014, 32'h0ABC_D005, 0);
        fill_cycle(1'b0);
        expect_resp("ro", 1'b1, 32'h0040_5123);
        // User read of same page walks again and succeeds
        issue(32'h0040_5123, 1'b0, 1'b1);
        mem_phase("ro2_pde", 32'h0001_0004, 32'h0002_0007, 0);
        mem_phase("ro2_pte", 32'h0002_0014, 32'h0ABC_D005, 0);
        fill_cycle(1'b0);
        expect_resp("ro2", 1'b0, 32'h0ABC_D123);

        // Non-present PDE: fault right after PDE data, no PTE read
        issue(32'h00C0_0000, 1'b0, 1'b0);
        mem_phase("np_pde", 32'h0001_000C, 32'h0000_0000, 2);
        expect_resp("np", 1'b1, 32'h00C0_0000);

        // Flush coinciding with the FILL write: response still correct
        issue(32'h0040_6ABC, 1'b0, 1'b0);
        mem_phase("fl_pde", 32'h0001_0004, 32'h0002_0007, 0);
        mem_phase("fl_pte", 32'h0002_0018, 32'h0077_7001, 0);
        fill_cycle(1'b1);
        expect_resp("fl", 1'b0, 32'h0077_7ABC);
        // Next request to the same page walks; supervisor write to U=0/W=0 is allowed
        issue(32'h0040_6ABC, 1'b1, 1'b0);
        mem_phase("fl2_pde", 32'h0001_0004, 32'h0002_0007, 0);
        mem_phase("fl2_pte", 32'h0002_0018, 32'h0077_7001, 0);
        fill_cycle(1'b0);
        expect_resp("sup_wr", 1'b0, 32'h0077_7ABC);
        // User read of a supervisor page faults (via TLB hit or walk)
        issue(32'h0040_6004, 1'b0, 1'b1);
`ifndef PAGING_UNIT_TLB_EN
        mem_phase("us_pde", 32'h0001_0004, 32'h0002_0007, 0);
        mem_phase("us_pte", 32'h0002_0018, 32'h0077_7001, 0);
        fill_cycle(1'b0);
`endif
        expect_resp("usr_sup", 1'b1, 32'h0040_6004);

        // Reset during WALK_PTE
        issue(32'h0040_3ABC, 1'b0, 1'b0);
        mem_phase("rs_pde", 32'h0001_0004, 32'h0002_0007, 0);
        @(negedge clock);
        chk("rs_in_pte", o_memory_request, 1);
        #1 reset = 1'b0;
        #1;
        chk("rs_memreq", o_memory_request, 0);
        chk("rs_ready", o_request_ready, 1);
        chk("rs_resp", o_response_valid, 0);
        chk("rs_fault", o_page_fault, 0);
        chk("rs_phys", o_physical_address, 0);
        chk("rs_cr2", o_fault_linear_address, 0);
        @(negedge clock);
        reset               = 1'b1;
        i_memory_data_valid = 1'b1;
        i_memory_data       = 32'h0ABC_D007;
        @(posedge clock); #1;
        i_memory_data_valid = 1'b0;
        @(negedge clock);
        chk("stale_memreq", o_memory_request, 0);
        chk("stale_resp", o_response_valid, 0);
        chk("stale_ready", o_request_ready, 1);
        @(posedge clock); #1;

        // Still functional after reset
        i_paging_enable = 1'b0;
        issue(32'hCAFE_0123, 1'b0, 1'b0);
        expect_resp("post_rst", 1'b0, 32'hCAFE_0123);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
